gmem_line_mover: RTL and testbench
==================================

# gmem_line_mover

Global-memory side controller for the compute-unit cache's port B. It takes line fill and line writeback requests from the miss handler and moves one cache line per request over a single-ID AXI-style burst interface. It also drives the cache's ticket protocol from the initiator side: it requests write tickets to push filled lines in and read tickets to pull dirty lines out with their byte enables. One request is in flight at a time. The line is buffered internally, so AXI back-pressure never stalls the cache port.

## Interface
Parameters:
- ADDR_W, 12: cache word address width (M+L); one cache word = WORD_W bits.
- WORD_W, 128: cache word and AXI data width (CACHE_N_BANKS*DATA_W).
- BEATS, 8: cache words per line; power of two, ≥2; AXI burst length.
- GADDR_W, 32: global byte address width.

Ports:
- clk  in  1  clock
- nrst  in  1  reset; synchronous, active-low
- req_valid  in  1  request from miss handler
- req_ready  out  1  accept; high only in IDLE
- req_wb  in  1  1 = writeback (cache→gmem), 0 = fill (gmem→cache)
- req_line  in  ADDR_W  line base cache address; low log2(BEATS) bits are ignored and treated as 0
- req_gaddr  in  GADDR_W  line base global byte address, line-aligned
- done  out  1  one-cycle pulse when the request completes
- err  out  1  valid with done; 1 if any AXI resp≠0 or a last-flag mismatch occurred
- ticket_rqst_wr / ticket_rqst_rd  out  1  ticket requests to cache
- ticket_ack_wr / ticket_ack_rd  in  1  one-cycle grants from cache
- wr_addr  out  ADDR_W  cache write address (wr_fifo_rqst_addr)
- wr_data  out  WORD_W  cache write data (wr_fifo_dout)
- rd_addr  out  ADDR_W  cache read line base (rd_fifo_rqst_addr)
- rd_valid  in  1  cache read word valid (rd_fifo_din_v)
- rd_data  in  WORD_W  cache read word (dob)
- rd_be  in  WORD_W/8  byte-dirty mask for rd_data (be_rdData)
- ar_valid, ar_ready, ar_addr[GADDR_W], ar_len[8]: read address channel
- r_valid, r_ready, r_data[WORD_W], r_resp[2], r_last: read data channel
- aw_valid, aw_ready, aw_addr[GADDR_W], aw_len[8]: write address channel
- w_valid, w_ready, w_data[WORD_W], w_strb[WORD_W/8], w_last: write data channel
- b_valid, b_ready, b_resp[2]: write response channel

## Operation
- Internal line buffer: BEATS × (WORD_W + WORD_W/8). Beat counter: log2(BEATS)+1 bits. The request (wb, line, gaddr) is latched on req_valid && req_ready.
- FSM states and transitions:
  - IDLE → FILL_AR or WB_TKT on accept.
  - Fill path: FILL_AR → FILL_R → FILL_TKT → FILL_PUSH → DONE.
  - Writeback path: WB_TKT → WB_COLLECT → WB_AW → WB_W → WB_B → DONE.
  - DONE → IDLE.
- FILL_AR:
  - ar_valid=1, ar_addr=gaddr, ar_len=BEATS-1.
  - ar_valid is held until ar_ready; the address is stable while valid.
- FILL_R:
  - r_ready=1. Each r_valid beat is stored at buf[cnt] and cnt increments.
  - Exit when cnt==BEATS.
  - r_last must arrive on beat BEATS-1; otherwise err is set. Extra beats are impossible under the single-burst rule and are not handled.
  - A nonzero r_resp sets err, but the data is still written into the cache.
- FILL_TKT: ticket_rqst_wr=1 until the cycle ticket_ack_wr=1, inclusive.
- FILL_PUSH: if the ack occurs in cycle t, then in cycles t+1+k for k=0..BEATS-1: wr_addr = line | k, wr_data = buf[k].
- WB_TKT: ticket_rqst_rd=1 until ticket_ack_rd=1, inclusive. When both request types could be pending, only one is ever raised (single request in flight).
- WB_COLLECT:
  - rd_addr = line, driven from the cycle after the ack and held stable through the state.
  - Each rd_valid beat captures {rd_data, rd_be} into buf[cnt]. Exit when cnt==BEATS.
  - rd_valid beats are accepted whenever they arrive; no fixed latency is assumed.
- WB_AW: aw_valid=1, aw_addr=gaddr, aw_len=BEATS-1; held until aw_ready.
- WB_W:
  - w_data=buf[cnt].data, w_strb=buf[cnt].be, w_last=(cnt==BEATS-1).
  - Advance on w_valid && w_ready.
  - Beats with w_strb==0 are still sent.
- WB_B: b_ready=1. b_resp≠0 sets err. Exit on b_valid.
- DONE: done=1 for one cycle with err; err clears on the next accept.
- Address arithmetic:
  - Cache address = {line[ADDR_W-1:log2 BEATS], k}. No carry into line bits; wrap stays inside the line.
  - The global address is never incremented (INCR burst, single AR/AW).

## Timing
- Reset value of every output is 0 (req_ready becomes 1 the cycle after reset releases, in IDLE).
- nrst low mid-operation: the next edge forces IDLE, cnt=0, err=0, and all valids and ticket requests to 0.
  - Any ticket already granted is abandoned.
  - The system-level reset also resets the cache and the AXI slave.
- All outputs are registered except req_ready and r_ready/b_ready, which decode the state only (never the inputs).
- Latencies:
  - Accept → ar_valid or ticket_rqst_rd: 1 cycle.
  - Last r beat → ticket_rqst_wr: 1 cycle.
  - Last rd_valid → aw_valid: 1 cycle.
  - b_valid → done: 1 cycle.
- A ticket ack arriving in the same cycle the request is first raised is honoured.
- With ready always high, the fill path takes 1 + BEATS + 1 + (ticket wait) + BEATS + 1 cycles.

## Test plan
- Fill, BEATS=8, line=0x040, gaddr=0x1000, r data i*0x11, ready always 1:
  - Expect ar_addr=0x1000, ar_len=7.
  - Expect wr_addr 0x040..0x047 with wr_data 0x00..0x77 in 8 consecutive cycles after ack.
  - Expect done=1, err=0.
- Writeback, line=0x07B (low bits ignored → 0x078):
  - rd_be alternates 0xFFFF/0x0000; aw_ready delayed 5 cycles, w_ready toggling.
  - Expect rd_addr=0x078 held, aw_addr=gaddr, 8 W beats with strobes alternating, w_last only on beat 7, done after b_valid.
- Ticket stall: delay ticket_ack_wr 20 cycles.
  - ticket_rqst_wr stays high exactly until the ack cycle, then wr pushes start at ack+1.
  - req_ready stays 0 throughout.
- Errors:
  - r_resp=2 on beat 3 → line still written, done with err=1.
  - r_last on beat 5 → err=1.
  - Writeback with b_resp=2 → err=1.
- Reset mid-WB_W (after 3 beats):
  - Next cycle all outputs are 0 and req_ready=1.
  - A new fill request completes normally with err=0.
- Back-to-back: req_valid held high across two requests.
  - Second accept occurs the cycle after done; no overlap of ticket requests.

Source files
------------

// File: rtl/gmem_line_mover_if.sv
// Bundle between the line mover and its environment: miss-handler request,
// cache ticket/port-B signals and the single-ID AXI-style burst channels.
interface gmem_line_mover_if #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned WORD_W  = 128,
  parameter int unsigned GADDR_W = 32
);
  localparam int unsigned BE_W = WORD_W / 8;

  logic               req_valid, req_ready, req_wb;
  logic [ADDR_W-1:0]  req_line;
  logic [GADDR_W-1:0] req_gaddr;
  logic               done, err;

  logic               ticket_rqst_wr, ticket_rqst_rd;
  logic               ticket_ack_wr, ticket_ack_rd;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WORD_W-1:0]  wr_data;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_valid;
  logic [WORD_W-1:0]  rd_data;
  logic [BE_W-1:0]    rd_be;

  logic               ar_valid, ar_ready;
  logic [GADDR_W-1:0] ar_addr;
  logic [7:0]         ar_len;
  logic               r_valid, r_ready, r_last;
  logic [WORD_W-1:0]  r_data;
  logic [1:0]         r_resp;
  logic               aw_valid, aw_ready;
  logic [GADDR_W-1:0] aw_addr;
  logic [7:0]         aw_len;
  logic               w_valid, w_ready, w_last;
  logic [WORD_W-1:0]  w_data;
  logic [BE_W-1:0]    w_strb;
  logic               b_valid, b_ready;
  logic [1:0]         b_resp;

  modport master (
    input  req_valid, req_wb, req_line, req_gaddr,
    input  ticket_ack_wr, ticket_ack_rd, rd_valid, rd_data, rd_be,
    input  ar_ready, r_valid, r_data, r_resp, r_last, aw_ready, w_ready, b_valid, b_resp,
    output req_ready, done, err, ticket_rqst_wr, ticket_rqst_rd, wr_addr, wr_data, rd_addr,
    output ar_valid, ar_addr, ar_len, r_ready, aw_valid, aw_addr, aw_len,
    output w_valid, w_data, w_strb, w_last, b_ready
  );

  modport slave (
    output req_valid, req_wb, req_line, req_gaddr,
    output ticket_ack_wr, ticket_ack_rd, rd_valid, rd_data, rd_be,
    output ar_ready, r_valid, r_data, r_resp, r_last, aw_ready, w_ready, b_valid, b_resp,
    input  req_ready, done, err, ticket_rqst_wr, ticket_rqst_rd, wr_addr, wr_data, rd_addr,
    input  ar_valid, ar_addr, ar_len, r_ready, aw_valid, aw_addr, aw_len,
    input  w_valid, w_data, w_strb, w_last, b_ready
  );
endinterface

// File: rtl/gmem_line_mover.sv
// Moves one cache line per request between the cache port B (ticket protocol)
// and global memory (single AXI burst), buffering the whole line internally.
module gmem_line_mover #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned WORD_W  = 128,
  parameter int unsigned BEATS   = 8,
  parameter int unsigned GADDR_W = 32
) (
  input logic                clk,
  input logic                nrst,
  gmem_line_mover_if.master  bus
);
  localparam int unsigned BE_W  = WORD_W / 8;
  localparam int unsigned LW    = $clog2(BEATS);
  localparam int unsigned CNT_W = LW + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BEATS);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL_AR, S_FILL_R, S_FILL_TKT, S_FILL_PUSH,
    S_WB_TKT, S_WB_COLLECT, S_WB_AW, S_WB_W, S_WB_B, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               live_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d, done_q, done_d;
  logic [ADDR_W-1:0]  line_q, line_d;
  logic [GADDR_W-1:0] gaddr_q, gaddr_d;
  logic [7:0]         len_q, len_d;
  logic               ar_valid_q, ar_valid_d, aw_valid_q, aw_valid_d;
  logic               w_valid_q, w_valid_d, w_last_q, w_last_d;
  logic [WORD_W-1:0]  w_data_q, w_data_d, wr_data_q, wr_data_d;
  logic [BE_W-1:0]    w_strb_q, w_strb_d;
  logic               rqst_wr_q, rqst_wr_d, rqst_rd_q, rqst_rd_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;

  logic [WORD_W-1:0]  lbuf_data_q [BEATS];
  logic [BE_W-1:0]    lbuf_be_q   [BEATS];
  logic               buf_we;
  logic [WORD_W-1:0]  buf_wdata;
  logic [BE_W-1:0]    buf_wbe;
  logic [LW-1:0]      idx, nxt;

  assign idx = cnt_q[LW-1:0];
  assign nxt = idx + LW'(1);

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    done_d     = done_q;
    line_d     = line_q;
    gaddr_d    = gaddr_q;
    len_d      = len_q;
    ar_valid_d = ar_valid_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    w_last_d   = w_last_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    rqst_wr_d  = rqst_wr_q;
    rqst_rd_d  = rqst_rd_q;
    buf_we     = 1'b0;
    buf_wdata  = bus.r_data;
    buf_wbe    = '1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && live_q) begin
          line_d  = {bus.req_line[ADDR_W-1:LW], LW'(0)};
          gaddr_d = bus.req_gaddr;
          len_d   = 8'(BEATS - 1);
          err_d   = 1'b0;
          cnt_d   = '0;
          if (bus.req_wb) begin
            state_d   = S_WB_TKT;
            rqst_rd_d = 1'b1;
          end else begin
            state_d    = S_FILL_AR;
            ar_valid_d = 1'b1;
          end
        end
      end
      S_FILL_AR: begin
        if (bus.ar_ready) begin
          ar_valid_d = 1'b0;
          state_d    = S_FILL_R;
        end
      end
      S_FILL_R: begin
        if (bus.r_valid) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (bus.r_resp != 2'b00 || bus.r_last != (cnt_q == LAST)) err_d = 1'b1;
          if (cnt_q == LAST) begin
            state_d   = S_FILL_TKT;
            rqst_wr_d = 1'b1;
            cnt_d     = '0;
          end
        end
      end
      S_FILL_TKT: begin
        if (bus.ticket_ack_wr) begin
          rqst_wr_d = 1'b0;
          wr_addr_d = line_q;
          wr_data_d = lbuf_data_q[0];
          cnt_d     = CNT_W'(1);
          state_d   = S_FILL_PUSH;
        end
      end
      S_FILL_PUSH: begin
        if (cnt_q == FULL) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          wr_addr_d = line_q | ADDR_W'(idx);
          wr_data_d = lbuf_data_q[idx];
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      S_WB_TKT: begin
        if (bus.ticket_ack_rd) begin
          rqst_rd_d = 1'b0;
          rd_addr_d = line_q;
          cnt_d     = '0;
          state_d   = S_WB_COLLECT;
        end
      end
      S_WB_COLLECT: begin
        if (bus.rd_valid) begin
          buf_we    = 1'b1;
          buf_wdata = bus.rd_data;
          buf_wbe   = bus.rd_be;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d    = S_WB_AW;
            aw_valid_d = 1'b1;
            cnt_d      = '0;
          end
        end
      end
      S_WB_AW: begin
        if (bus.aw_ready) begin
          aw_valid_d = 1'b0;
          w_valid_d  = 1'b1;
          w_data_d   = lbuf_data_q[0];
          w_strb_d   = lbuf_be_q[0];
          w_last_d   = 1'b0;
          state_d    = S_WB_W;
        end
      end
      S_WB_W: begin
        if (bus.w_ready) begin
          if (cnt_q == LAST) begin
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
            cnt_d     = '0;
            state_d   = S_WB_B;
          end else begin
            cnt_d    = cnt_q + CNT_W'(1);
            w_data_d = lbuf_data_q[nxt];
            w_strb_d = lbuf_be_q[nxt];
            w_last_d = (cnt_q + CNT_W'(1)) == LAST;
          end
        end
      end
      S_WB_B: begin
        if (bus.b_valid) begin
          if (bus.b_resp != 2'b00) err_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      live_q     <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      line_q     <= '0;
      gaddr_q    <= '0;
      len_q      <= '0;
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      w_last_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rqst_wr_q  <= 1'b0;
      rqst_rd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= 1'b1;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      line_q     <= line_d;
      gaddr_q    <= gaddr_d;
      len_q      <= len_d;
      ar_valid_q <= ar_valid_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      w_last_q   <= w_last_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rqst_wr_q  <= rqst_wr_d;
      rqst_rd_q  <= rqst_rd_d;
    end
  end

  // Line buffer holds data only; its contents are meaningless until written
  always_ff @(posedge clk) begin
    if (buf_we) begin
      lbuf_data_q[idx] <= buf_wdata;
      lbuf_be_q[idx]   <= buf_wbe;
    end
  end

  // req_ready waits one cycle after reset release so it reads 0 under reset
  assign bus.req_ready      = live_q && (state_q == S_IDLE);
  assign bus.r_ready        = (state_q == S_FILL_R);
  assign bus.b_ready        = (state_q == S_WB_B);
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.ticket_rqst_wr = rqst_wr_q;
  assign bus.ticket_rqst_rd = rqst_rd_q;
  assign bus.wr_addr        = wr_addr_q;
  assign bus.wr_data        = wr_data_q;
  assign bus.rd_addr        = rd_addr_q;
  assign bus.ar_valid       = ar_valid_q;
  assign bus.ar_addr        = gaddr_q;
  assign bus.ar_len         = len_q;
  assign bus.aw_valid       = aw_valid_q;
  assign bus.aw_addr        = gaddr_q;
  assign bus.aw_len         = len_q;
  assign bus.w_valid        = w_valid_q;
  assign bus.w_data         = w_data_q;
  assign bus.w_strb         = w_strb_q;
  assign bus.w_last         = w_last_q;
endmodule

// File: tb/tb_gmem_line_mover.sv
// Randomized self-checking bench for gmem_line_mover; plays miss handler,
// cache port B and AXI slave, predicting each line transfer from its own arrays.
module tb_gmem_line_mover;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned WORD_W  = 128;
  localparam int unsigned BEATS   = 8;
  localparam int unsigned GADDR_W = 32;

  logic clk, nrst;
  int   n_chk, n_bad;

  gmem_line_mover_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .GADDR_W(GADDR_W)) bus ();

  gmem_line_mover #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .BEATS(BEATS), .GADDR_W(GADDR_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [11:0] line_base(input logic [11:0] line);
    return 12'((int'(line) / BEATS) * BEATS);
  endfunction

  task automatic drive_idle();
    bus.req_valid = 0; bus.req_wb = 0; bus.req_line = '0; bus.req_gaddr = '0;
    bus.ticket_ack_wr = 0; bus.ticket_ack_rd = 0;
    bus.rd_valid = 0; bus.rd_data = '0; bus.rd_be = '0;
    bus.ar_ready = 0; bus.r_valid = 0; bus.r_data = '0; bus.r_resp = '0; bus.r_last = 0;
    bus.aw_ready = 0; bus.w_ready = 0; bus.b_valid = 0; bus.b_resp = '0;
  endtask

  task automatic chk_quiet();
    chk("q_done", bus.done, 0);        chk("q_err", bus.err, 0);
    chk("q_tkt_wr", bus.ticket_rqst_wr, 0); chk("q_tkt_rd", bus.ticket_rqst_rd, 0);
    chk("q_ar_valid", bus.ar_valid, 0); chk("q_aw_valid", bus.aw_valid, 0);
    chk("q_w_valid", bus.w_valid, 0);   chk("q_w_last", bus.w_last, 0);
    chk("q_w_data", bus.w_data, 0);     chk("q_w_strb", bus.w_strb, 0);
    chk("q_wr_addr", bus.wr_addr, 0);   chk("q_wr_data", bus.wr_data, 0);
    chk("q_rd_addr", bus.rd_addr, 0);   chk("q_ar_addr", bus.ar_addr, 0);
    chk("q_ar_len", bus.ar_len, 0);     chk("q_aw_len", bus.aw_len, 0);
    chk("q_r_ready", bus.r_ready, 0);   chk("q_b_ready", bus.b_ready, 0);
  endtask

  // Present a request and step through its accept edge
  task automatic issue(input bit wb, input logic [11:0] line, input logic [31:0] gaddr,
                       input bit want_now, input bit hold);
    int w;
    w = 0;
    bus.req_valid = 1; bus.req_wb = wb; bus.req_line = line; bus.req_gaddr = gaddr;
    while (!bus.req_ready && w < 200) begin
      tick();
      w++;
    end
    if (want_now) chk("b2b_accept_wait", w, 0);
    if (!bus.req_ready) chk("req_ready_timeout", 0, 1);
    tick();
    if (!hold) bus.req_valid = 0;
    chk("req_ready_busy", bus.req_ready, 0);
  endtask

  // emode: 0 clean, 1 r_resp=2 on beat 3, 2 r_last on beat 5, 4 random bad resp
  task automatic run_fill(input logic [11:0] line, input logic [31:0] gaddr, input int emode,
                          input int ack_wait, input bit hold, input bit want_now, input bit pattern);
    logic [127:0] d [BEATS];
    logic [1:0]   rs [BEATS];
    int           lpos;
    bit           exp_err;
    logic [11:0]  base;
    base = line_base(line);
    lpos = BEATS - 1;
    for (int k = 0; k < BEATS; k++) begin
      d[k]  = pattern ? 128'(k * 'h11) : rnd_word();
      rs[k] = 2'b00;
    end
    if (emode == 1) rs[3] = 2'd2;
    if (emode == 2) lpos = 5;
    if (emode == 4) rs[$urandom_range(0, BEATS-1)] = 2'($urandom_range(1, 3));
    exp_err = (lpos != BEATS - 1);
    for (int k = 0; k < BEATS; k++) if (rs[k] != 2'b00) exp_err = 1;

    issue(0, line, gaddr, want_now, hold);
    chk("ar_valid", bus.ar_valid, 1);
    chk("ar_addr", bus.ar_addr, gaddr);
    chk("ar_len", bus.ar_len, BEATS - 1);
    chk("fill_no_tkt_rd", bus.ticket_rqst_rd, 0);
    if (!pattern) begin
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("ar_hold", bus.ar_valid, 1);
        chk("ar_addr_hold", bus.ar_addr, gaddr);
      end
    end
    bus.ar_ready = 1;
    tick();
    bus.ar_ready = 0;
    chk("ar_drop", bus.ar_valid, 0);
    for (int k = 0; k < BEATS; k++) begin
      if (!pattern) repeat ($urandom_range(0, 2)) begin
        chk("r_ready", bus.r_ready, 1);
        tick();
      end
      bus.r_valid = 1; bus.r_data = d[k]; bus.r_resp = rs[k]; bus.r_last = (k == lpos);
      tick();
      bus.r_valid = 0; bus.r_last = 0; bus.r_resp = 2'b00;
    end
    chk("tkt_wr_latency", bus.ticket_rqst_wr, 1);
    chk("r_ready_off", bus.r_ready, 0);
    repeat (ack_wait) begin
      chk("tkt_wr_hold", bus.ticket_rqst_wr, 1);
      chk("tkt_excl_rd", bus.ticket_rqst_rd, 0);
      chk("stall_req_ready", bus.req_ready, 0);
      tick();
    end
    bus.ticket_ack_wr = 1;
    chk("tkt_wr_ack_cycle", bus.ticket_rqst_wr, 1);
    tick();
    bus.ticket_ack_wr = 0;
    chk("tkt_wr_drop", bus.ticket_rqst_wr, 0);
    for (int k = 0; k < BEATS; k++) begin
      chk("wr_addr", bus.wr_addr, base + 12'(k));
      chk("wr_data", bus.wr_data, d[k]);
      tick();
    end
    chk("fill_done", bus.done, 1);
    chk("fill_err", bus.err, exp_err);
    tick();
    chk("done_pulse", bus.done, 0);
    chk("idle_ready", bus.req_ready, 1);
  endtask

  task automatic run_wb(input logic [11:0] line, input logic [31:0] gaddr, input logic [1:0] bresp,
                        input int ack_wait, input int aw_dly, input bit hold, input bit want_now,
                        input bit rnd_be, input int abort_after);
    logic [127:0] d [BEATS];
    logic [15:0]  be [BEATS];
    logic [11:0]  base;
    int           k, cyc;
    bit           rdy;
    base = line_base(line);
    for (int i = 0; i < BEATS; i++) begin
      d[i]  = rnd_word();
      if (rnd_be) be[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      else        be[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
    end

    issue(1, line, gaddr, want_now, hold);
    chk("tkt_rd_latency", bus.ticket_rqst_rd, 1);
    chk("wb_no_tkt_wr", bus.ticket_rqst_wr, 0);
    chk("wb_no_ar", bus.ar_valid, 0);
    repeat (ack_wait) begin
      chk("tkt_rd_hold", bus.ticket_rqst_rd, 1);
      chk("tkt_excl_wr", bus.ticket_rqst_wr, 0);
      tick();
    end
    bus.ticket_ack_rd = 1;
    tick();
    bus.ticket_ack_rd = 0;
    chk("tkt_rd_drop", bus.ticket_rqst_rd, 0);
    chk("rd_addr", bus.rd_addr, base);
    for (int i = 0; i < BEATS; i++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("rd_addr_hold", bus.rd_addr, base);
      end
      bus.rd_valid = 1; bus.rd_data = d[i]; bus.rd_be = be[i];
      tick();
      bus.rd_valid = 0;
    end
    chk("aw_valid", bus.aw_valid, 1);
    chk("aw_addr", bus.aw_addr, gaddr);
    chk("aw_len", bus.aw_len, BEATS - 1);
    repeat (aw_dly) begin
      tick();
      chk("aw_hold", bus.aw_valid, 1);
    end
    bus.aw_ready = 1;
    tick();
    bus.aw_ready = 0;
    chk("aw_drop", bus.aw_valid, 0);
    k = 0;
    cyc = 0;
    while (k < BEATS && cyc < 200) begin
      chk("w_valid", bus.w_valid, 1);
      chk("w_data", bus.w_data, d[k]);
      chk("w_strb", bus.w_strb, be[k]);
      chk("w_last", bus.w_last, (k == BEATS - 1));
      if (k == abort_after) begin
        bus.w_ready = 0;
        nrst = 0;
        tick();
        nrst = 1;
        chk_quiet();
        chk("rst_req_ready", bus.req_ready, 0);
        tick();
        chk("rst_release_ready", bus.req_ready, 1);
        chk("rst_release_w_valid", bus.w_valid, 0);
        return;
      end
      rdy = rnd_be ? 1'($urandom_range(0, 1)) : (cyc % 2 == 1);
      bus.w_ready = rdy;
      tick();
      if (rdy) k++;
      cyc++;
    end
    bus.w_ready = 0;
    if (k < BEATS) chk("w_timeout", k, BEATS);
    chk("w_valid_off", bus.w_valid, 0);
    repeat ($urandom_range(0, 3)) begin
      chk("b_ready", bus.b_ready, 1);
      tick();
    end
    bus.b_valid = 1; bus.b_resp = bresp;
    tick();
    bus.b_valid = 0; bus.b_resp = 2'b00;
    chk("wb_done", bus.done, 1);
    chk("wb_err", bus.err, (bresp != 2'b00));
    tick();
    chk("done_pulse", bus.done, 0);
    chk("idle_ready", bus.req_ready, 1);
  endtask

  initial begin
    bit          prev_hold, hold, wb;
    logic [11:0] line;
    logic [31:0] g;
    n_chk = 0;
    n_bad = 0;
    drive_idle();
    nrst = 0;
    repeat (3) tick();
    chk_quiet();
    chk("reset_req_ready", bus.req_ready, 0);
    nrst = 1;
    tick();
    chk("post_reset_ready", bus.req_ready, 1);

    run_fill(12'h040, 32'h1000, 0, 0, 0, 0, 1);
    run_wb(12'h07B, 32'h2000, 2'b00, 2, 5, 0, 0, 0, -1);
    run_fill(12'h123, 32'h3080, 0, 20, 0, 0, 0);
    run_fill(12'h200, 32'h4000, 1, 1, 0, 0, 0);
    run_fill(12'h208, 32'h4080, 2, 0, 0, 0, 0);
    run_wb(12'h311, 32'h5000, 2'd2, 0, 1, 0, 0, 1, -1);
    run_wb(12'h0C6, 32'h6000, 2'b00, 1, 0, 0, 0, 1, 3);
    run_fill(12'h0A5, 32'h7000, 0, 3, 0, 0, 0);
    run_fill(12'h150, 32'h8000, 0, 1, 1, 0, 0);
    run_wb(12'h157, 32'h8080, 2'b00, 0, 2, 1, 1, 1, -1);
    run_fill(12'h3FF, 32'h9000, 0, 0, 0, 1, 0);

    prev_hold = 0;
    for (int i = 0; i < 24; i++) begin
      hold = (i != 23) && ($urandom_range(0, 3) == 0);
      wb   = 1'($urandom_range(0, 1));
      line = 12'($urandom);
      g    = $urandom & 32'hFFFF_FF80;
      if (wb)
        run_wb(line, g, ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
               $urandom_range(0, 6), $urandom_range(0, 4), hold, prev_hold, 1, -1);
      else
        run_fill(line, g, ($urandom_range(0, 3) == 0) ? 4 : 0, $urandom_range(0, 6),
                 hold, prev_hold, 0);
      prev_hold = hold;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
